// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with a programmable tick prescaler and a load/start/stop/expiry FSM.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the count from rl_val on expiry.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] out_t,
  output logic [3:0] out_tens,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO_RL = 1'b1;
`else
  localparam bit AUTO_RL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [7:0]    r_rl;
  logic          r_running;
  logic          r_done;

  logic [3:0]    w_ld_tens;
  logic [3:0]    w_ld_ones;
  logic          w_zero;
  logic          w_last;
  logic          w_tick;
  logic          w_reload;

  // Out-of-range BCD nibbles saturate to 9
  assign w_ld_tens = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
  assign w_ld_ones = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];

  assign w_zero   = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_last   = (r_tens == 4'd0) && (r_ones == 4'd1);
  assign w_tick   = (r_pre == PW'(TICK_DIV - 1));
  assign w_reload = AUTO_RL && (r_rl != 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_rl      <= 8'h00;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_tens    <= w_ld_tens;
        r_ones    <= w_ld_ones;
        r_rl      <= {w_ld_tens, w_ld_ones};
        r_pre     <= '0;
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else if (stop && (r_state == RUN)) begin
        // Prescaler is kept so a resume continues the partial tick
        r_state   <= PAUSE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE, PAUSE: begin
            if (start && !w_zero) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            if (!w_tick) begin
              r_pre <= r_pre + PW'(1);
            end else begin
              r_pre <= '0;
              if (w_last) begin
                r_done <= 1'b1;
                if (w_reload) begin
                  r_tens <= r_rl[7:4];
                  r_ones <= r_rl[3:0];
                end else begin
                  r_ones    <= 4'd0;
                  r_state   <= IDLE;
                  r_running <= 1'b0;
                end
              end else if (r_ones != 4'd0) begin
                r_ones <= r_ones - 4'd1;
              end else begin
                r_ones <= 4'd9;
                r_tens <= r_tens - 4'd1;
              end
            end
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_t    = r_ones;
  assign out_tens = r_tens;
  assign running  = r_running;
  assign done     = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: decimal reference model feeding an expected-value queue.
module tb_countdown_timer;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       stop;
  logic [3:0] out_t;
  logic [3:0] out_tens;
  logic       running;
  logic       done;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .out_t(out_t), .out_tens(out_tens),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  // Reference model: count kept as a plain integer 0..99
  int m_cnt, m_rl, m_st, m_pre;
  bit m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_rl = 0; m_st = 0; m_pre = 0; m_done = 1'b0;
  endtask

  function automatic logic [9:0] m_pack();
    return {4'(m_cnt / 10), 4'(m_cnt % 10), 1'(m_st == 1), m_done};
  endfunction

  task automatic m_step();
    int t, o;
    m_done = 1'b0;
    if (load) begin
      t = int'(load_val[7:4]); if (t > 9) t = 9;
      o = int'(load_val[3:0]); if (o > 9) o = 9;
      m_cnt = t * 10 + o; m_rl = m_cnt; m_pre = 0; m_st = 0;
    end else if (stop && m_st == 1) begin
      m_st = 2;
    end else if (m_st != 1) begin
      if (start && m_cnt != 0) m_st = 1;
    end else if (m_pre == int'(TD) - 1) begin
      m_pre = 0;
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (m_rl != 0) m_cnt = m_rl; else m_st = 0;
`else
        m_st = 0;
`endif
      end
    end else begin
      m_pre = m_pre + 1;
    end
  endtask

  task automatic drive(input logic l, input logic [7:0] lv, input logic s, input logic p);
    load = l; load_val = lv; start = s; stop = p;
  endtask

  // One clock: predict, push, clock, pop and compare
  task automatic cyc(input string tag);
    m_step();
    exp_q.push_back(m_pack());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk({tag, "_q_empty"}, 32'd0, 32'd1);
    else chk(tag, {out_tens, out_t, running, done}, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    m_reset();
    #12;
    chk("reset_val", {out_tens, out_t, running, done}, 10'h000);
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;

    // Load 12, start: 11, 10, then borrow to 09
    drive(1'b1, 8'h12, 1'b0, 1'b0); cyc("load12");
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start12");
    chk("run_rise", running, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (12) cyc("count12");
    chk("borrow_09", {out_tens, out_t, running}, {8'h09, 1'b1});

    // Load 02: expiry pulse
    drive(1'b1, 8'h02, 1'b0, 1'b0); cyc("load02");
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start02");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (8) cyc("count02");
    chk("done_pulse", {out_tens, out_t, done}, {8'h00, 1'b1});
    cyc("post_expiry");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("after_exp", {out_tens, out_t, running, done}, {8'h02, 1'b1, 1'b0});
`else
    chk("after_exp", {out_tens, out_t, running, done}, {8'h00, 1'b0, 1'b0});
`endif
    repeat (20) cyc("run_on");

    // Pause / resume keeps the partial tick
    drive(1'b1, 8'h05, 1'b0, 1'b0); cyc("load05");
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start05");
    drive(1'b0, 8'h00, 1'b0, 1'b0); cyc("run05");
    drive(1'b0, 8'h00, 1'b0, 1'b1); cyc("stop05");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (9) cyc("pause05");
    chk("pause_hold", {out_tens, out_t, running}, {8'h05, 1'b0});
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("resume05");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (6) cyc("after_resume");

    // Saturation and load while running
    drive(1'b1, 8'hAF, 1'b0, 1'b0); cyc("loadAF");
    chk("sat_99", {out_tens, out_t}, 8'h99);
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start99");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (5) cyc("run99");
    drive(1'b1, 8'h34, 1'b0, 1'b0); cyc("load34_run");
    chk("load_in_run", {out_tens, out_t, running}, {8'h34, 1'b0});

    // Load coinciding with the expiry tick wins
    drive(1'b1, 8'h01, 1'b0, 1'b0); cyc("load01");
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start01");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) cyc("run01");
    drive(1'b1, 8'h25, 1'b0, 1'b0); cyc("load_on_exp");
    chk("load_beats_exp", {out_tens, out_t, done}, {8'h25, 1'b0});

    // Start ignored at 00
    drive(1'b1, 8'h00, 1'b0, 1'b0); cyc("load00");
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start00");
    chk("start_at_00", running, 0);

    // Stop coinciding with a tick suppresses the decrement
    drive(1'b1, 8'h03, 1'b0, 1'b0); cyc("load03");
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start03");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) cyc("run03");
    drive(1'b0, 8'h00, 1'b0, 1'b1); cyc("stop_on_tick");
    chk("stop_beats_tick", {out_tens, out_t, running}, {8'h03, 1'b0});

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(39) == 0), 8'($urandom), ($urandom_range(5) == 0),
            ($urandom_range(11) == 0));
      cyc("rand");
    end

    // Asynchronous reset mid-run at 37
    drive(1'b1, 8'h37, 1'b0, 1'b0); cyc("load37");
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start37");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) cyc("run37");
    chk("pre_reset", {out_tens, out_t, running}, {8'h37, 1'b1});
    #2; rst = 1'b1; #1;
    m_reset();
    chk("async_reset", {out_tens, out_t, running, done}, 10'h000);
    @(posedge clk); #3; rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc("start_after_rst");
    chk("start_after_rst_idle", running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
